serial_pair_tx: RTL and testbench

//   Bit-serial stimulus source for the two-line serial comparator/adder FSM.

---
 rtl/serial_pair_tx_if.sv | 12 +
 rtl/serial_pair_tx.sv | 127 ++++++++++++
 tb/tb_serial_pair_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pair_tx_if.sv
// Parallel operand-pair handshake between a host/test source and serial_pair_tx.
interface serial_pair_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    modport master (output in_valid, output in_a, output in_b, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/serial_pair_tx.sv
// Shifts an accepted operand pair out LSB-first on line1/line2 with frame/last
// markers, followed by a programmable idle gap.
module serial_pair_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clock,
    input  logic             reset,
    serial_pair_tx_if.slave  s_in,
    output logic             line1,
    output logic             line2,
    output logic             frame,
    output logic             last,
    output logic             busy
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
    localparam logic [3:0]    GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_gcnt;
    logic             r_line1;
    logic             r_line2;
    logic             r_frame;
    logic             r_last;
    logic             r_busy;
    logic             r_ready;
    logic             w_load;

    // r_ready is high exactly in IDLE and in the GAP==0 last-bit cycle, so one
    // load branch covers both the idle accept and the back-to-back reload.
    assign w_load = s_in.in_valid && r_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_line1 <= 1'b0;
            r_line2 <= 1'b0;
            r_frame <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else if (w_load) begin
            r_state <= S_SHIFT;
            r_sh_a  <= s_in.in_a >> 1;
            r_sh_b  <= s_in.in_b >> 1;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_line1 <= s_in.in_a[0];
            r_line2 <= s_in.in_b[0];
            r_frame <= 1'b1;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_line1 <= 1'b0;
                    r_line2 <= 1'b0;
                    r_frame <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                S_SHIFT: begin
                    if (r_cnt != CNT_LAST) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_line1 <= r_sh_a[0];
                        r_line2 <= r_sh_b[0];
                        r_sh_a  <= r_sh_a >> 1;
                        r_sh_b  <= r_sh_b >> 1;
                        r_frame <= 1'b1;
                        r_last  <= (r_cnt == CNT_PEN);
                        r_busy  <= 1'b1;
                        r_ready <= (r_cnt == CNT_PEN) && (GAP == 0);
                    end else begin
                        r_line1 <= 1'b0;
                        r_line2 <= 1'b0;
                        r_frame <= 1'b0;
                        r_last  <= 1'b0;
                        r_gcnt  <= '0;
                        if (GAP == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_gcnt  <= r_gcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign line1         = r_line1;
    assign line2         = r_line2;
    assign frame         = r_frame;
    assign last          = r_last;
    assign busy          = r_busy;
    assign s_in.in_ready = r_ready;
endmodule

// File: tb/tb_serial_pair_tx.sv
// Scoreboard bench: two DUTs (GAP=1 and GAP=0) checked every cycle against a
// cycle-window model and a per-bit expectation queue.
module tb_serial_pair_tx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         drv_v [2];
    logic [W-1:0] drv_a [2];
    logic [W-1:0] drv_b [2];
    logic         o_l1 [2];
    logic         o_l2 [2];
    logic         o_fr [2];
    logic         o_la [2];
    logic         o_bu [2];
    logic         o_rd [2];

    serial_pair_tx_if #(.WIDTH(W)) if0 ();
    serial_pair_tx_if #(.WIDTH(W)) if1 ();

    assign if0.in_valid = drv_v[0];
    assign if0.in_a     = drv_a[0];
    assign if0.in_b     = drv_b[0];
    assign if1.in_valid = drv_v[1];
    assign if1.in_a     = drv_a[1];
    assign if1.in_b     = drv_b[1];
    assign o_rd[0]      = if0.in_ready;
    assign o_rd[1]      = if1.in_ready;

    serial_pair_tx #(.WIDTH(W), .GAP(1)) dut0 (
        .clock(clk), .reset(rst), .s_in(if0.slave),
        .line1(o_l1[0]), .line2(o_l2[0]), .frame(o_fr[0]), .last(o_la[0]), .busy(o_bu[0])
    );
    serial_pair_tx #(.WIDTH(W), .GAP(0)) dut1 (
        .clock(clk), .reset(rst), .s_in(if1.slave),
        .line1(o_l1[1]), .line2(o_l2[1]), .frame(o_fr[1]), .last(o_la[1]), .busy(o_bu[1])
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int kacc    [2];
    int free_at [2];
    bit acc_flag [2];
    logic [2:0] q0 [$];
    logic [2:0] q1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor / reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        int g;
        bit ef, eb, er, acc;
        logic [2:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                kacc[i]     = -1000;
                free_at[i]  = cyc + 2;
                acc_flag[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                g  = gap_of(i);
                ef = (cyc >= kacc[i] + 1) && (cyc <= kacc[i] + W);
                eb = (cyc >= kacc[i] + 1) && (cyc <= kacc[i] + W + g);
                er = (cyc >= free_at[i]) || (g == 0 && cyc == kacc[i] + W);
                chk("frame", i, 32'(o_fr[i]), 32'(ef));
                chk("busy", i, 32'(o_bu[i]), 32'(eb));
                chk("in_ready", i, 32'(o_rd[i]), 32'(er));
                if (o_fr[i]) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("unexpected_bit", i, 32'(1), 32'(0));
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk("line1", i, 32'(o_l1[i]), 32'(e[2]));
                        chk("line2", i, 32'(o_l2[i]), 32'(e[1]));
                        chk("last", i, 32'(o_la[i]), 32'(e[0]));
                    end
                end else begin
                    chk("idle_lines", i, {29'd0, o_l1[i], o_l2[i], o_la[i]}, 32'd0);
                end
                acc = drv_v[i] && er;
                acc_flag[i] = acc;
                if (acc) begin
                    kacc[i]    = cyc;
                    free_at[i] = cyc + W + g + 1;
                    for (int j = 0; j < W; j++) begin
                        e = {drv_a[i][j], drv_b[i][j], (j == W - 1)};
                        if (i == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                end
            end
        end
    end

    // Callers are at posedge+1; returns at posedge+1 of the first data-bit cycle.
    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        bit ok;
        ok = 1'b0;
        drv_a[i] = a;
        drv_b[i] = b;
        drv_v[i] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (acc_flag[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", i, 32'(0), 32'(1));
        if (!hold) drv_v[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            drv_v[i] = 1'b0;
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 0, 32'(o_rd[0]), 32'(0));
        chk("reset_busy", 1, 32'(o_bu[1]), 32'(0));
        #1 rst = 1'b0;
        idle(1);

        send(0, 8'hA5, 8'h3C, 1'b0);
        idle(12);

        send(1, 8'hFF, 8'h00, 1'b1);
        send(1, 8'h00, 8'hFF, 1'b0);
        idle(12);

        send(0, 8'h5A, 8'hC3, 1'b0);
        drv_a[0] = 8'h00;
        drv_b[0] = 8'hFF;
        idle(2);
        drv_v[0] = 1'b1;
        drv_a[0] = 8'($urandom);
        idle(1);
        drv_v[0] = 1'b0;
        idle(5);
        chk("ready_in_gap", 0, 32'(o_rd[0]), 32'(0));
        drv_v[0] = 1'b1;
        idle(1);
        drv_v[0] = 1'b0;
        idle(4);

        send(0, 8'hFF, 8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_line1", 0, 32'(o_l1[0]), 32'(0));
        chk("rst_line2", 0, 32'(o_l2[0]), 32'(0));
        chk("rst_frame", 0, 32'(o_fr[0]), 32'(0));
        chk("rst_busy", 0, 32'(o_bu[0]), 32'(0));
        chk("rst_ready", 0, 32'(o_rd[0]), 32'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        idle(1);
        send(0, 8'h96, 8'h0F, 1'b0);
        idle(12);

        fork
            begin
                send(0, 8'hFF, 8'hFF, 1'b0);
                send(0, 8'h00, 8'h00, 1'b0);
            end
            begin
                send(1, 8'hFF, 8'hFF, 1'b0);
                send(1, 8'h00, 8'h00, 1'b0);
            end
        join
        idle(12);

        fork
            for (int n = 0; n < 30; n++) begin
                bit h0;
                h0 = ($urandom_range(0, 1) == 1) && (n != 29);
                send(0, 8'($urandom), 8'($urandom), h0);
                if (!h0) idle($urandom_range(0, 3));
            end
            for (int n = 0; n < 30; n++) begin
                bit h1;
                h1 = ($urandom_range(0, 1) == 1) && (n != 29);
                send(1, 8'($urandom), 8'($urandom), h1);
                if (!h1) idle($urandom_range(0, 3));
            end
        join
        idle(20);

        chk("drain_q0", 0, 32'(q0.size()), 32'(0));
        chk("drain_q1", 1, 32'(q1.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
